// File: rtl/ssm_output_fp16_if.sv
// Producer-side bundle for the SSM output stage: pass control plus the flattened
// h/C/D/x operands and the y results.
interface ssm_output_fp16_if #(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int N  = 4,
    parameter int DW = 16
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [B*H*P*N*DW-1:0]     h_flat;
    logic [B*N*DW-1:0]         C_flat;
    logic [H*DW-1:0]           D_flat;
    logic [B*H*P*DW-1:0]       x_flat;
    logic [B*H*P*DW-1:0]       y_flat;

    modport master (output start, h_flat, C_flat, D_flat, x_flat, input y_flat, busy, done);
    modport slave  (input start, h_flat, C_flat, D_flat, x_flat, output y_flat, busy, done);
endinterface

// File: rtl/ssm_output_fp16.sv
// Mamba-2 SSM output stage: y = sum_n h*C + D*x per element, one shared FP16
// multiplier and adder, fixed left-to-right accumulation with D*x added last.
package ssm_fp16_pkg;
    // Round-to-nearest-even packing of the exact value m * 2^ex into FP16.
    function automatic logic [15:0] fp16_round_pack(input logic s, input int ex, input logic [63:0] m);
        int msb, be, sh;
        logic [63:0] q, rem, half, total;
        logic up;
        logic [15:0] res;
        msb = 0;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) msb = i;
            else msb = msb;
        end
        be = (msb + ex + 15 < 1) ? 1 : msb + ex + 15;
        sh = be - 25 - ex;
        q = 64'd0; rem = 64'd0; half = 64'd1; up = 1'b0;
        if (sh <= 0) begin
            q = m << (-sh);
        end else if (sh < 63) begin
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
        end else begin
            q = 64'd0;
        end
        // Hidden bit of q carries into the exponent field, covering subnormals and overflow
        total = 64'(be - 1) * 64'd1024 + q + 64'(up);
        if (m == 64'd0) res = {s, 15'd0};
        else if (total >= 64'h7C00) res = {s, 15'h7C00};
        else res = {s, total[14:0]};
        return res;
    endfunction

    function automatic int fp16_exp(input logic [15:0] a);
        return (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    endfunction

    function automatic logic [10:0] fp16_man(input logic [15:0] a);
        return {(a[14:10] != 5'd0), a[9:0]};
    endfunction

    function automatic logic fp16_is_nan(input logic [15:0] a);
        return (&a[14:10]) && (|a[9:0]);
    endfunction

    function automatic logic fp16_is_inf(input logic [15:0] a);
        return (&a[14:10]) && !(|a[9:0]);
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        logic [15:0] r;
        s = a[15] ^ b[15];
        if (fp16_is_nan(a) || fp16_is_nan(b) ||
            (fp16_is_inf(a) && b[14:0] == 15'd0) || (fp16_is_inf(b) && a[14:0] == 15'd0))
            r = 16'h7E00;
        else if (fp16_is_inf(a) || fp16_is_inf(b))
            r = {s, 15'h7C00};
        else
            r = fp16_round_pack(s, fp16_exp(a) + fp16_exp(b) - 50,
                                64'(fp16_man(a)) * 64'(fp16_man(b)));
        return r;
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, emin;
        logic [63:0] am, bm, m;
        logic s;
        logic [15:0] r;
        ea = fp16_exp(a); eb = fp16_exp(b);
        emin = (ea < eb) ? ea : eb;
        // Exact alignment by shifting the larger operand up; at most 30 bits
        am = 64'(fp16_man(a)) << (ea - emin);
        bm = 64'(fp16_man(b)) << (eb - emin);
        if (a[15] == b[15]) begin
            m = am + bm; s = a[15];
        end else if (am > bm) begin
            m = am - bm; s = a[15];
        end else if (bm > am) begin
            m = bm - am; s = b[15];
        end else begin
            m = 64'd0; s = 1'b0;
        end
        if (fp16_is_nan(a) || fp16_is_nan(b) || (fp16_is_inf(a) && fp16_is_inf(b) && a[15] != b[15]))
            r = 16'h7E00;
        else if (fp16_is_inf(a))
            r = a;
        else if (fp16_is_inf(b))
            r = b;
        else
            r = fp16_round_pack(s, emin - 25, m);
        return r;
    endfunction
endpackage

module fp16_mult_wrapper #(parameter int LAT = 6) (
    input  logic        clk,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    logic [LAT-1:0] vld_r;
    logic [15:0]    pipe_r [LAT];

    // Product formed on entry, then delayed to the IP latency; no reset by design
    always_ff @(posedge clk) begin
        vld_r     <= {vld_r[LAT-2:0], valid_in};
        pipe_r[0] <= ssm_fp16_pkg::fp16_mul(a, b);
        for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end

    assign valid_out = vld_r[LAT-1];
    assign result    = pipe_r[LAT-1];
endmodule

module fp16_add_wrapper #(parameter int LAT = 11) (
    input  logic        clk,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    logic [LAT-1:0] vld_r;
    logic [15:0]    pipe_r [LAT];

    // Sum formed on entry, then delayed to the IP latency; no reset by design
    always_ff @(posedge clk) begin
        vld_r     <= {vld_r[LAT-2:0], valid_in};
        pipe_r[0] <= ssm_fp16_pkg::fp16_add(a, b);
        for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end

    assign valid_out = vld_r[LAT-1];
    assign result    = pipe_r[LAT-1];
endmodule

module ssm_output_fp16 #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int M_LAT = 6,
    parameter int A_LAT = 11
) (
    input logic               clk,
    input logic               rst,
    ssm_output_fp16_if.slave  bus
);
    localparam int NE        = B * H * P;
    localparam int EW        = (NE > 1) ? $clog2(NE) : 1;
    localparam int SW        = $clog2(N + 1);
    localparam int DRAIN_LEN = M_LAT + A_LAT + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAITM = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;

    logic [2:0]         state_r;
    logic [7:0]         cnt_r;
    logic [EW-1:0]      e_r;
    logic [SW-1:0]      step_r, cap_r;
    logic [DW-1:0]      prod_r [N+1];
    logic [DW-1:0]      acc_r;
    logic [NE*DW-1:0]   y_r;
    logic               busy_r, done_r;

    logic               mul_vi_s, mul_vo_s, add_vi_s, add_vo_s;
    logic [DW-1:0]      mul_a_s, mul_b_s, mul_res_s, add_a_s, add_b_s, add_res_s;
    int                 e_s, k_s, bt_s, hd_s;

    assign e_s  = int'(e_r);
    assign k_s  = int'(cnt_r);
    assign bt_s = e_s / (H * P);
    assign hd_s = (e_s / P) % H;

    // Multiplier operands: N state products, then the D*x skip term
    always_comb begin
        mul_vi_s = 1'b0;
        mul_a_s  = {DW{1'b0}};
        mul_b_s  = {DW{1'b0}};
        if (state_r == S_ISSUE) begin
            mul_vi_s = 1'b1;
            if (k_s < N) begin
                mul_a_s = bus.h_flat[(e_s * N + k_s) * DW +: DW];
                mul_b_s = bus.C_flat[(bt_s * N + k_s) * DW +: DW];
            end else begin
                mul_a_s = bus.D_flat[hd_s * DW +: DW];
                mul_b_s = bus.x_flat[e_s * DW +: DW];
            end
        end else begin
            mul_vi_s = 1'b0;
        end
    end

    assign add_vi_s = (state_r == S_ACC) && (cnt_r == 8'd0);
    assign add_a_s  = (step_r == SW'(1)) ? prod_r[0] : acc_r;
    assign add_b_s  = prod_r[step_r];

    fp16_mult_wrapper #(.LAT(M_LAT)) u_mul (
        .clk(clk), .valid_in(mul_vi_s), .a(mul_a_s), .b(mul_b_s),
        .valid_out(mul_vo_s), .result(mul_res_s)
    );

    fp16_add_wrapper #(.LAT(A_LAT)) u_add (
        .clk(clk), .valid_in(add_vi_s), .a(add_a_s), .b(add_b_s),
        .valid_out(add_vo_s), .result(add_res_s)
    );

    // Pass sequencer, product capture, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_DRAIN;
            cnt_r   <= 8'd0;
            e_r     <= {EW{1'b0}};
            step_r  <= {SW{1'b0}};
            cap_r   <= {SW{1'b0}};
            acc_r   <= {DW{1'b0}};
            y_r     <= {(NE*DW){1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            for (int i = 0; i <= N; i++) prod_r[i] <= {DW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r <= S_ISSUE;
                        e_r     <= {EW{1'b0}};
                        cnt_r   <= 8'd0;
                        cap_r   <= {SW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (cnt_r == 8'(N)) begin
                        state_r <= S_WAITM;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                S_WAITM: begin
                    if (cnt_r == 8'(M_LAT - 1)) begin
                        state_r <= S_ACC;
                        cnt_r   <= 8'd0;
                        step_r  <= SW'(1);
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                S_ACC: begin
                    // One add in flight: issue at count 0, result lands at count A_LAT
                    if (cnt_r == 8'(A_LAT)) begin
                        cnt_r <= 8'd0;
                        if (step_r == SW'(N)) state_r <= S_WRITE;
                        else step_r <= step_r + SW'(1);
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                S_WRITE: begin
                    y_r[e_s * DW +: DW] <= acc_r;
                    cnt_r <= 8'd0;
                    cap_r <= {SW{1'b0}};
                    if (e_r == EW'(NE - 1)) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        e_r     <= e_r + EW'(1);
                        state_r <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_DRAIN: begin
                    if (cnt_r == 8'(DRAIN_LEN - 1)) begin
                        state_r <= S_IDLE;
                        cnt_r   <= 8'd0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= S_DRAIN;
                    cnt_r   <= 8'd0;
                    busy_r  <= 1'b1;
                end
            endcase
            if (mul_vo_s && (state_r == S_ISSUE || state_r == S_WAITM || state_r == S_ACC)
                && cap_r <= SW'(N)) begin
                prod_r[cap_r] <= mul_res_s;
                cap_r         <= cap_r + SW'(1);
            end
            if (add_vo_s && state_r == S_ACC) acc_r <= add_res_s;
        end
    end

    assign bus.y_flat = y_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_ssm_output_fp16.sv
// Directed bench for ssm_output_fp16: drain, basic, index, rounding order,
// start-while-busy and mid-pass reset, against hand-derived FP16 results.
module tb_ssm_output_fp16;
    localparam int NE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] exp_y [NE];

    ssm_output_fp16_if bus ();

    ssm_output_fp16 dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] int2h(input int v);
        int m;
        logic [15:0] r;
        if (v == 0) return 16'h0000;
        m = 0;
        for (int i = 0; i < 11; i++) if (v >= (1 << i)) m = i;
        r[15]    = 1'b0;
        r[14:10] = 5'(m + 15);
        r[9:0]   = 10'((v << (10 - m)) & 1023);
        return r;
    endfunction

    task automatic set_basic();
        for (int g = 0; g < 64; g++) bus.h_flat[g*16 +: 16] = 16'h3C00;
        for (int n = 0; n < 4; n++)  bus.C_flat[n*16 +: 16] = 16'h3800;
        for (int h = 0; h < 4; h++)  bus.D_flat[h*16 +: 16] = 16'h3C00;
        for (int e = 0; e < NE; e++) begin
            bus.x_flat[e*16 +: 16] = 16'h4000;
            exp_y[e] = 16'h4400;
        end
    endtask

    task automatic set_index();
        for (int g = 0; g < 64; g++) bus.h_flat[g*16 +: 16] = int2h(g);
        for (int n = 0; n < 4; n++)  bus.C_flat[n*16 +: 16] = 16'h3C00;
        for (int h = 0; h < 4; h++)  bus.D_flat[h*16 +: 16] = 16'h0000;
        for (int e = 0; e < NE; e++) begin
            bus.x_flat[e*16 +: 16] = 16'h0000;
            exp_y[e] = int2h(16 * e + 6);
        end
    endtask

    task automatic set_order();
        for (int g = 0; g < 64; g++) bus.h_flat[g*16 +: 16] = (g % 4 == 0) ? 16'h6800 : 16'h3800;
        for (int n = 0; n < 4; n++)  bus.C_flat[n*16 +: 16] = 16'h3C00;
        for (int h = 0; h < 4; h++)  bus.D_flat[h*16 +: 16] = 16'h3C00;
        for (int e = 0; e < NE; e++) begin
            bus.x_flat[e*16 +: 16] = 16'h3C00;
            exp_y[e] = 16'h6800;
        end
    endtask

    task automatic check_y(input string tag);
        for (int e = 0; e < NE; e++)
            check_eq($sformatf("%s_y%0d", tag, e), {16'd0, bus.y_flat[e*16 +: 16]}, {16'd0, exp_y[e]});
    endtask

    // Holds rst 3 cycles with start pulsed every cycle; returns at the first idle cycle
    task automatic reset_and_drain();
        int lows = 0;
        int dones = 0;
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_y_zero", {31'd0, |bus.y_flat}, 32'd0);
            check_eq("rst_done", {31'd0, bus.done}, 32'd0);
            check_eq("rst_busy", {31'd0, bus.busy}, 32'd1);
        end
        rst = 1'b0;
        for (int j = 1; j < 18; j++) begin
            @(negedge clk);
            if (!bus.busy) lows++;
            if (bus.done) dones++;
        end
        check_eq("drain_busy_low_cycles", lows, 0);
        check_eq("drain_done_pulses", dones, 0);
        @(negedge clk);
        check_eq("drain_end_idle", {31'd0, bus.busy}, 32'd0);
        check_eq("drain_y_zero", {31'd0, |bus.y_flat}, 32'd0);
    endtask

    // Starts a pass in the current cycle and follows it for 962 cycles (or until abort_at)
    task automatic run_pass(input int extra, input int abort_at,
                            output int dcyc, output int ndone, output int c0);
        c0 = cyc;
        check_eq("idle_before_start", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b1;
        dcyc = -1;
        ndone = 0;
        for (int i = 1; i <= 962; i++) begin
            @(negedge clk);
            bus.start = (i == extra);
            if (bus.done) begin
                ndone++;
                if (dcyc < 0) dcyc = i;
            end
            if (i == 1) check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
            if (i == abort_at) break;
        end
        if (abort_at == 0) check_eq("busy_clear_962", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int d, nd, s1, s2, s3;
        bus.start = 1'b0;
        set_basic();
        reset_and_drain();

        run_pass(100, 0, d, nd, s1);
        check_eq("basic_done_cycle", d, 961);
        check_eq("basic_done_count", nd, 1);
        check_y("basic");

        @(negedge clk);
        set_index();
        run_pass(0, 0, d, nd, s2);
        check_eq("second_start_cycle", s2 - s1, 963);
        check_eq("second_done_abs", s2 + d - s1, 963 + 960 + 1);
        check_eq("index_done_count", nd, 1);
        check_y("index");
        check_eq("index_y3_const", {16'd0, bus.y_flat[3*16 +: 16]}, 32'h52C0);

        set_order();
        run_pass(0, 0, d, nd, s3);
        check_eq("order_done_cycle", d, 961);
        check_y("order");

        set_basic();
        run_pass(0, 200, d, nd, s3);
        check_eq("abort_no_done", nd, 0);
        reset_and_drain();
        bus.start = 1'b0;
        run_pass(0, 0, d, nd, s3);
        check_eq("rerun_done_cycle", d, 961);
        check_eq("rerun_done_count", nd, 1);
        check_y("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
